// File: rtl/ysyx_23060025_sys_ctrl.sv
// System-instruction sequencer: issues one CSRRW/CSRRS/ECALL/MRET to the CSR file
// per accepted op, then returns the old CSR value to WBU or redirects IFU.
module ysyx_23060025_sys_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int ECALL_CAUSE = 11
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [3:0]            op_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    output logic [11:0]           csr_addr_o,
    output logic [2:0]            csr_type_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic [DATA_WIDTH-1:0] csr_mepc_o,
    output logic [DATA_WIDTH-1:0] csr_mcause_o,
    input  logic [DATA_WIDTH-1:0] csr_rdata_i,
    input  logic [DATA_WIDTH-1:0] csr_pc_i,
    output logic                  wb_valid_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic                  wb_ready_i,
    output logic                  redir_valid_o,
    output logic [DATA_WIDTH-1:0] redir_pc_o,
    input  logic                  redir_ready_i,
    output logic [CNT_WIDTH-1:0]  ecall_cnt_o
);

    localparam logic [2:0] T_NONE  = 3'b000;
    localparam logic [2:0] T_CSRW  = 3'b001;
    localparam logic [2:0] T_CSRS  = 3'b010;
    localparam logic [2:0] T_ECALL = 3'b011;
    localparam logic [2:0] T_MRET  = 3'b101;

    // state  | meaning
    // IDLE   | ready for a new op
    // ISSUE  | single cycle driving the CSR file
    // WAITPC | CSR file computes trap/return target
    // REDIR  | redirect offered to IFU
    // WB     | old CSR value offered to WBU
    typedef enum logic [2:0] {IDLE, ISSUE, WAITPC, REDIR, WB} state_t;

    state_t                state;
    logic [2:0]            op_type;
    logic [2:0]            op_code;
    logic [11:0]           addr_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] rs1_q;
    logic                  issue;

    always_comb begin
        op_code = T_NONE;
        if (op_i[3])      op_code = T_ECALL;
        else if (op_i[2]) op_code = T_MRET;
        else if (op_i[1]) op_code = T_CSRW;
        else if (op_i[0]) op_code = T_CSRS;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            ready_o       <= 1'b1;
            wb_valid_o    <= 1'b0;
            wb_data_o     <= '0;
            redir_valid_o <= 1'b0;
            redir_pc_o    <= '0;
            ecall_cnt_o   <= '0;
            op_type       <= T_NONE;
            addr_q        <= '0;
            pc_q          <= '0;
            rs1_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        op_type <= op_code;
                        addr_q  <= csr_addr_i;
                        pc_q    <= pc_i;
                        rs1_q   <= rs1_data_i;
                        ready_o <= 1'b0;
                        // A NOP never touches the CSR file.
                        if (op_code == T_NONE) begin
                            wb_data_o  <= '0;
                            wb_valid_o <= 1'b1;
                            state      <= WB;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (op_type == T_CSRW || op_type == T_CSRS) begin
                        wb_data_o  <= csr_rdata_i;
                        wb_valid_o <= 1'b1;
                        state      <= WB;
                    end else begin
                        state <= WAITPC;
                    end
                    if (op_type == T_ECALL && ecall_cnt_o != '1)
                        ecall_cnt_o <= ecall_cnt_o + CNT_WIDTH'(1);
                end
                WAITPC: begin
                    redir_pc_o    <= csr_pc_i;
                    redir_valid_o <= 1'b1;
                    state         <= REDIR;
                end
                REDIR: begin
                    if (redir_ready_i) begin
                        redir_valid_o <= 1'b0;
                        ready_o       <= 1'b1;
                        state         <= IDLE;
                    end
                end
                WB: begin
                    if (wb_ready_i) begin
                        wb_valid_o <= 1'b0;
                        ready_o    <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

    assign issue        = (state == ISSUE);
    assign csr_addr_o   = issue ? addr_q : 12'h000;
    assign csr_type_o   = issue ? op_type : T_NONE;
    assign csr_wdata_o  = (issue && op_type == T_CSRW) ? rs1_q :
                          (issue && op_type == T_CSRS) ? (csr_rdata_i | rs1_q) : '0;
    assign csr_mepc_o   = (issue && op_type == T_ECALL) ? pc_q : '0;
    assign csr_mcause_o = (issue && op_type == T_ECALL) ? DATA_WIDTH'(ECALL_CAUSE) : '0;

endmodule
